reg_file_sb: RTL and testbench



---
 rtl/reg_file_pkg.sv | 16 +
 rtl/reg_scoreboard.sv | 59 +++++
 rtl/reg_file_sb.sv | 74 +++++++
 tb/tb_reg_file_sb.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the architectural register file.
package reg_file_pkg;

  localparam int N_DEF = 32;
  localparam int A_DEF = 5;
  localparam int R     = 2 ** A_DEF;

  typedef logic [A_DEF-1:0] reg_idx_t;
  typedef logic [N_DEF-1:0] word_t;

  // True when a writeback targets a real (storage-backed) register.
  function automatic logic idx_valid(input reg_idx_t idx);
    return (idx != '0);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending scoreboard: issue sets, writeback clears, set wins.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int A = A_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [A-1:0] ra1,
  input  logic [A-1:0] ra2,
  input  logic         we,
  input  logic [A-1:0] wa,
  input  logic         issue_en,
  input  logic [A-1:0] issue_rd,
  output logic         busy1,
  output logic         busy2,
  output logic         any_busy
);

  localparam int RL = 1 << A;

  logic [RL-1:0] r_busy;
  logic [RL-1:0] w_set;
  logic [RL-1:0] w_clr;
  logic [RL-1:0] w_busy_nxt;
  logic          w_hit1;
  logic          w_hit2;

  // Decode set/clear masks; index 0 never gets a pending bit.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int i = 1; i < RL; i++) begin
      w_set[i] = issue_en && (issue_rd == A'(i));
      w_clr[i] = we && (wa == A'(i));
    end
    // A new producer supersedes the one writing back this cycle.
    w_busy_nxt = (r_busy & ~w_clr) | w_set;
  end

  // Busy vector state, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // A value bypassed from writeback this cycle is not reported busy.
  always_comb begin
    w_hit1   = we && (wa == ra1);
    w_hit2   = we && (wa == ra2);
    busy1    = rst_n && (ra1 != '0) && r_busy[ra1] && !w_hit1;
    busy2    = rst_n && (ra2 != '0) && r_busy[ra2] && !w_hit2;
    any_busy = rst_n && (|r_busy[RL-1:1]);
  end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two bypassed read ports, one write port and scoreboard.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int A = A_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [A-1:0] ra1,
  input  logic [A-1:0] ra2,
  output logic [N-1:0] rd1,
  output logic [N-1:0] rd2,
  input  logic         we,
  input  logic [A-1:0] wa,
  input  logic [N-1:0] wd,
  input  logic         issue_en,
  input  logic [A-1:0] issue_rd,
  output logic         busy1,
  output logic         busy2,
  output logic         any_busy
);

  localparam int RL = 1 << A;

  // Entry 0 is never written, so it holds zero and folds away.
  logic [N-1:0] r_regs [RL];

  // Storage array update; writes to index 0 are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RL; i++) begin
        r_regs[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      r_regs[wa] <= wd;
    end
  end

  // Read muxes: reset forcing, zero register, then same-cycle write bypass.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (!rst_n || (ra1 == '0)) begin
      rd1 = '0;
    end else if (we && (wa == ra1)) begin
      rd1 = wd;
    end else begin
      rd1 = r_regs[ra1];
    end
    if (!rst_n || (ra2 == '0)) begin
      rd2 = '0;
    end else if (we && (wa == ra2)) begin
      rd2 = wd;
    end else begin
      rd2 = r_regs[ra2];
    end
  end

  reg_scoreboard #(.A(A)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra1      (ra1),
    .ra2      (ra2),
    .we       (we),
    .wa       (wa),
    .issue_en (issue_en),
    .issue_rd (issue_rd),
    .busy1    (busy1),
    .busy2    (busy2),
    .any_busy (any_busy)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench: array-based reference model plus directed literal checks.
module tb_reg_file_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa, issue_rd;
  logic [31:0] rd1, rd2, wd;
  logic        we, issue_en;
  logic        busy1, busy2, any_busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [31:0] m_regs [32];
  logic        m_busy [32];

  reg_file_sb #(.N(32), .A(5)) dut (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .issue_en(issue_en), .issue_rd(issue_rd),
    .busy1(busy1), .busy2(busy2), .any_busy(any_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the architectural state.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] <= 32'h0;
        m_busy[i] <= 1'b0;
      end
    end else begin
      if (we && wa != 5'd0) begin
        m_regs[wa] <= wd;
        m_busy[wa] <= 1'b0;
      end
      if (issue_en && issue_rd != 5'd0) m_busy[issue_rd] <= 1'b1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    if (!rst_n || ra == 5'd0) return 32'h0;
    if (we && wa == ra) return wd;
    return m_regs[ra];
  endfunction

  function automatic logic exp_busy(input logic [4:0] ra);
    if (!rst_n || ra == 5'd0) return 1'b0;
    if (we && wa == ra) return 1'b0;
    return m_busy[ra];
  endfunction

  function automatic logic exp_any();
    logic acc = 1'b0;
    for (int i = 1; i < 32; i++) acc = acc | m_busy[i];
    return rst_n && acc;
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rd1_model",   rd1, exp_rd(ra1));
      check("rd2_model",   rd2, exp_rd(ra2));
      check("busy1_model", {31'd0, busy1}, {31'd0, exp_busy(ra1)});
      check("busy2_model", {31'd0, busy2}, {31'd0, exp_busy(ra2)});
      check("any_model",   {31'd0, any_busy}, {31'd0, exp_any()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; wa = 5'd0; wd = 32'h0; issue_en = 1'b0; issue_rd = 5'd0;
  endtask

  initial begin
    rst_n = 1'b0;
    ra1 = 5'd3; ra2 = 5'd0;
    we = 1'b1; wa = 5'd3; wd = 32'hDEAD_BEEF;
    issue_en = 1'b1; issue_rd = 5'd3;
    #3;
    chk_en = 1'b1;
    check("rst_rd1", rd1, 32'h0);
    check("rst_busy1", {31'd0, busy1}, 32'd0);
    step(); step();
    check("rst_rd1_hold", rd1, 32'h0);
    check("rst_any", {31'd0, any_busy}, 32'd0);
    idle();
    rst_n = 1'b1;
    step();
    check("post_rst_rd1", rd1, 32'h0);

    // write then read, with same-cycle bypass on port 2
    we = 1'b1; wa = 5'd5; wd = 32'h1234_5678; ra2 = 5'd5;
    #1 check("bypass_rd2", rd2, 32'h1234_5678);
    step();
    idle(); ra1 = 5'd5;
    #1 check("read_rd1", rd1, 32'h1234_5678);
    step();

    // register 0
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0;
    issue_en = 1'b1; issue_rd = 5'd0;
    #1 check("r0_rd1_wcyc", rd1, 32'h0);
    step();
    idle();
    #1 check("r0_rd1_after", rd1, 32'h0);
    check("r0_any", {31'd0, any_busy}, 32'd0);
    step();

    // RAW hazard on register 7
    ra1 = 5'd7; issue_en = 1'b1; issue_rd = 5'd7;
    #1 check("haz_busy_k", {31'd0, busy1}, 32'd0);
    step();
    idle();
    #1 check("haz_busy_k1", {31'd0, busy1}, 32'd1);
    check("haz_any", {31'd0, any_busy}, 32'd1);
    step(); step();
    we = 1'b1; wa = 5'd7; wd = 32'd9;
    #1 check("haz_wb_busy", {31'd0, busy1}, 32'd0);
    check("haz_wb_rd1", rd1, 32'd9);
    step();
    idle();
    #1 check("haz_after_busy", {31'd0, busy1}, 32'd0);
    check("haz_after_rd1", rd1, 32'd9);
    check("haz_after_any", {31'd0, any_busy}, 32'd0);
    step();

    // same-cycle set and clear on register 4
    issue_en = 1'b1; issue_rd = 5'd4; ra1 = 5'd4;
    step();
    we = 1'b1; wa = 5'd4; wd = 32'hA5A5_0004;
    #1 check("sc_bypass_rd1", rd1, 32'hA5A5_0004);
    step();
    idle();
    #1 check("sc_busy1", {31'd0, busy1}, 32'd1);
    check("sc_rd1", rd1, 32'hA5A5_0004);
    step();

    // directed table: fill registers 8..15 while issuing to neighbours
    for (int i = 8; i < 16; i++) begin
      we = 1'b1; wa = 5'(i); wd = 32'h0101_0101 * 32'(i);
      issue_en = 1'b1; issue_rd = 5'(i + 1);
      ra1 = 5'(i); ra2 = 5'(i + 1);
      step();
    end
    idle();
    ra1 = 5'd10; ra2 = 5'd16;
    #1 check("tbl_rd1", rd1, 32'h0A0A_0A0A);
    check("tbl_busy2", {31'd0, busy2}, 32'd1);
    step();

    // reset pulse mid-operation with busy[2], busy[9] and nonzero regs
    we = 1'b1; wa = 5'd2; wd = 32'h0000_0222; issue_en = 1'b1; issue_rd = 5'd9;
    step();
    idle(); issue_en = 1'b1; issue_rd = 5'd2;
    step();
    idle(); ra1 = 5'd2; ra2 = 5'd9;
    #1 check("mid_pre_any", {31'd0, any_busy}, 32'd1);
    check("mid_pre_busy1", {31'd0, busy1}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check("mid_any", {31'd0, any_busy}, 32'd0);
    check("mid_rd1", rd1, 32'h0);
    check("mid_rd2", rd2, 32'h0);
    #3 rst_n = 1'b1;
    step();
    check("mid_post_rd1", rd1, 32'h0);
    check("mid_post_rd2", rd2, 32'h0);
    check("mid_post_busy2", {31'd0, busy2}, 32'd0);
    ra1 = 5'd5;
    #1 check("mid_post_r5", rd1, 32'h0);
    step(); step();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
